// File: rtl/mmio_result_monitor_pkg.sv
// Shared types, default parameters and the channel address helper for mmio_result_monitor.
package mmio_result_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam int          DEF_DATA_WIDTH     = 32;
    localparam int          DEF_ADDR_WIDTH     = 32;
    localparam int          DEF_NUM_CH         = 4;
    localparam logic [63:0] DEF_BASE_ADDR      = 64'd0;
    localparam logic [63:0] DEF_ADDR_STRIDE    = 64'd4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;
    localparam int          DEF_CNT_WIDTH      = 32;

    // Byte address of result channel idx; callers truncate to their bus width.
    function automatic logic [63:0] chan_addr(input logic [63:0] base,
                                              input logic [63:0] stride,
                                              input int unsigned idx);
        return base + stride * 64'(idx);
    endfunction

endpackage

// File: rtl/mmio_result_monitor_watchdog.sv
// Saturating RUN-cycle counter; expired flags the last cycle before the timeout limit.
module monitor_watchdog
    import mmio_result_monitor_pkg::*;
#(
    parameter int          CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 expired
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            count_reg <= '0;
        end else if (en && count_reg != '1) begin
            count_reg <= count_reg + CNT_WIDTH'(1);
        end
    end

    assign count   = count_reg;
    assign expired = en && (count_reg == LIMIT);

endmodule

// File: rtl/mmio_result_monitor.sv
// Result sink snooping the dmem write bus; checks NUM_CH result words and reports done/pass/timeout.
// Optional macro MMIO_RESULT_MONITOR_STOP_ON_MISMATCH_EN ends the run on the first wrong masked capture.
module mmio_result_monitor
    import mmio_result_monitor_pkg::*;
#(
    parameter int          DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int          ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int          NUM_CH         = DEF_NUM_CH,
    parameter logic [63:0] BASE_ADDR      = DEF_BASE_ADDR,
    parameter logic [63:0] ADDR_STRIDE    = DEF_ADDR_STRIDE,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         clear,
    input  logic                         memwrite,
    input  logic [ADDR_WIDTH-1:0]        dataadr,
    input  logic [DATA_WIDTH-1:0]        writedata,
    input  logic [NUM_CH-1:0]            exp_mask,
    input  logic [NUM_CH*DATA_WIDTH-1:0] exp_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [NUM_CH-1:0]            cap_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] cap_data,
    output logic [NUM_CH-1:0]            dup_write,
    output logic [CNT_WIDTH-1:0]         cycle_count,
    output logic [CNT_WIDTH-1:0]         write_count
);

    state_t                       state_reg, state_next;
    logic [NUM_CH-1:0]            cap_valid_reg, cap_valid_next;
    logic [NUM_CH*DATA_WIDTH-1:0] cap_data_reg, cap_data_next;
    logic [NUM_CH-1:0]            dup_reg, dup_next;
    logic [NUM_CH-1:0]            hit, first_hit, match_next;
    logic                         pass_reg;
    logic [CNT_WIDTH-1:0]         write_count_reg;
    logic                         run, complete, expired, stop_now;

    assign run = (state_reg == ST_RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [63:0] CH_ADDR = chan_addr(BASE_ADDR, ADDR_STRIDE, gi);

            assign hit[gi]        = run && memwrite && (dataadr == CH_ADDR[ADDR_WIDTH-1:0]);
            assign first_hit[gi]  = hit[gi] && !cap_valid_reg[gi];
            assign cap_valid_next[gi] = cap_valid_reg[gi] | hit[gi];
            assign dup_next[gi]   = dup_reg[gi] | (hit[gi] & cap_valid_reg[gi]);
            assign cap_data_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                first_hit[gi] ? writedata : cap_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
            // Unmasked channels count as matching so they never veto pass.
            assign match_next[gi] = !exp_mask[gi] ||
                (cap_data_next[gi*DATA_WIDTH +: DATA_WIDTH] == exp_data[gi*DATA_WIDTH +: DATA_WIDTH]);
        end
    endgenerate

`ifdef MMIO_RESULT_MONITOR_STOP_ON_MISMATCH_EN
    logic [NUM_CH-1:0] bad_first;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_bad
            assign bad_first[gi] = first_hit[gi] && exp_mask[gi] &&
                (writedata != exp_data[gi*DATA_WIDTH +: DATA_WIDTH]);
        end
    endgenerate
    assign stop_now = |bad_first;
`else
    assign stop_now = 1'b0;
`endif

    // Completion looks at next-state captures so the last write and DONE share an edge.
    assign complete = &(cap_valid_next | ~exp_mask);

    monitor_watchdog #(
        .CNT_WIDTH      (CNT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .en      (run),
        .clr     (clear),
        .count   (cycle_count),
        .expired (expired)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (complete || stop_now) state_next = ST_DONE;
                else if (expired)         state_next = ST_TIMEOUT;
            end
            default: state_next = state_reg;
        endcase
        if (clear) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state_reg       <= ST_IDLE;
            cap_valid_reg   <= '0;
            cap_data_reg    <= '0;
            dup_reg         <= '0;
            pass_reg        <= 1'b0;
            write_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cap_valid_reg <= cap_valid_next;
            cap_data_reg  <= cap_data_next;
            dup_reg       <= dup_next;
            if (run && memwrite && write_count_reg != '1)
                write_count_reg <= write_count_reg + CNT_WIDTH'(1);
            if (run && state_next == ST_DONE)
                pass_reg <= &match_next;
        end
    end

    assign busy        = (state_reg == ST_RUN);
    assign done        = (state_reg == ST_DONE);
    assign timeout     = (state_reg == ST_TIMEOUT);
    assign pass        = done && pass_reg;
    assign cap_valid   = cap_valid_reg;
    assign cap_data    = cap_data_reg;
    assign dup_write   = dup_reg;
    assign write_count = write_count_reg;

endmodule

// File: tb/tb_mmio_result_monitor.sv
// Scoreboard bench for mmio_result_monitor: stimulus queues expected snapshots, a monitor compares them.
module tb_mmio_result_monitor;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, clear = 1'b0, memwrite = 1'b0;
    logic [31:0]  dataadr = '0, writedata = '0;
    logic [3:0]   exp_mask = '0;
    logic [127:0] exp_data = '0;
    logic         busy, done, pass, timeout;
    logic [3:0]   cap_valid, dup_write;
    logic [127:0] cap_data;
    logic [31:0]  cycle_count, write_count;

    always #5 clk = ~clk;

    mmio_result_monitor #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CH(4), .BASE_ADDR(64'd0),
        .ADDR_STRIDE(64'd4), .TIMEOUT_CYCLES(10), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .clear(clear),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_mask(exp_mask), .exp_data(exp_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .cap_valid(cap_valid), .cap_data(cap_data), .dup_write(dup_write),
        .cycle_count(cycle_count), .write_count(write_count)
    );

    typedef struct {
        string        name;
        logic         done, pass, timeout, busy;
        logic [3:0]   cv;
        logic [127:0] cd;
        logic [3:0]   dup;
        logic [31:0]  cyc, wc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic probe_req = 1'b0;

    function automatic exp_t mk(string nm, logic d, logic p, logic t, logic b, logic [3:0] cv,
                                logic [127:0] cd, logic [3:0] dup, logic [31:0] cyc, logic [31:0] wc);
        exp_t e;
        e.name = nm; e.done = d; e.pass = p; e.timeout = t; e.busy = b;
        e.cv = cv; e.cd = cd; e.dup = dup; e.cyc = cyc; e.wc = wc;
        return e;
    endfunction

    task automatic cmp(string nm, logic [127:0] act, logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: compares on every terminal rise (done/timeout) and on explicit probes.
    initial begin : monitor
        logic term, prev_term;
        exp_t e;
        prev_term = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            term = done | timeout;
            if (probe_req || (term && !prev_term)) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output: done=%0b timeout=%0b with empty scoreboard", done, timeout);
                end else begin
                    e = sb.pop_front();
                    cmp({e.name, ".done"},    128'(done),        128'(e.done));
                    cmp({e.name, ".pass"},    128'(pass),        128'(e.pass));
                    cmp({e.name, ".timeout"}, 128'(timeout),     128'(e.timeout));
                    cmp({e.name, ".busy"},    128'(busy),        128'(e.busy));
                    cmp({e.name, ".cap_valid"}, 128'(cap_valid), 128'(e.cv));
                    cmp({e.name, ".cap_data"},  cap_data,        e.cd);
                    cmp({e.name, ".dup_write"}, 128'(dup_write), 128'(e.dup));
                    cmp({e.name, ".cycle_count"}, 128'(cycle_count), 128'(e.cyc));
                    cmp({e.name, ".write_count"}, 128'(write_count), 128'(e.wc));
                    $display("check %s: done=%0b pass=%0b timeout=%0b cap_valid=%b cyc=%0d wr=%0d",
                             e.name, done, pass, timeout, cap_valid, cycle_count, write_count);
                end
            end
            prev_term = term;
        end
    end

    task automatic drv(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic st, input logic cl, input logic rn = 1'b1);
        @(negedge clk);
        probe_req = 1'b0;
        memwrite = mw; dataadr = a; writedata = wd;
        start = st; clear = cl; rst_n = rn;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic probe(input string nm);
        sb.push_back(mk(nm, 0, 0, 0, 0, 4'h0, '0, 4'h0, 0, 0));
        probe_req = 1'b1;
    endtask

    localparam logic [127:0] DATA_4321 = {32'd4, 32'd3, 32'd2, 32'd1};

    initial begin : stimulus
        // Reset state
        drv(0, 0, 0, 0, 0, 1'b0); probe("reset");
        // Write in IDLE is ignored
        drv(1, 32'h0, 32'hAA, 0, 0); probe("idle_write");

        // Nominal: one idle RUN cycle, then four writes -> cycle_count 5, write_count 4
        exp_mask = 4'hF; exp_data = DATA_4321;
        sb.push_back(mk("nominal", 1, 1, 0, 0, 4'hF, DATA_4321, 4'h0, 5, 4));
        drv(0, 0, 0, 1, 0); idle(1);
        drv(1, 32'h0, 1, 0, 0); drv(1, 32'h4, 2, 0, 0);
        drv(1, 32'h8, 3, 0, 0); drv(1, 32'hC, 4, 0, 0);
        idle(2);
        drv(0, 0, 0, 0, 1); probe("clear_nominal");

        // Mismatch on channel 2
`ifdef MMIO_RESULT_MONITOR_STOP_ON_MISMATCH_EN
        sb.push_back(mk("mismatch", 1, 0, 0, 0, 4'b0111, {32'd0, 32'd5, 32'd2, 32'd1}, 4'h0, 4, 3));
`else
        sb.push_back(mk("mismatch", 1, 0, 0, 0, 4'hF, {32'd4, 32'd5, 32'd2, 32'd1}, 4'h0, 5, 4));
`endif
        drv(0, 0, 0, 1, 0); idle(1);
        drv(1, 32'h0, 1, 0, 0); drv(1, 32'h4, 2, 0, 0);
        drv(1, 32'h8, 5, 0, 0); drv(1, 32'hC, 4, 0, 0);
        idle(2);
        drv(0, 0, 0, 0, 1); probe("clear_mismatch");

        // Timeout: no writes, limit 10 RUN cycles
        exp_mask = 4'b0001;
        sb.push_back(mk("timeout", 0, 0, 1, 0, 4'h0, '0, 4'h0, 10, 0));
        drv(0, 0, 0, 1, 0); idle(13);
        drv(0, 0, 0, 0, 1); probe("clear_timeout");

        // Duplicate and off-channel writes
        exp_mask = 4'b0011; exp_data = {32'd0, 32'd0, 32'd8, 32'd7};
        sb.push_back(mk("dup_write", 1, 1, 0, 0, 4'b0011, {32'd0, 32'd0, 32'd8, 32'd7}, 4'b0001, 4, 4));
        drv(0, 0, 0, 1, 0);
        drv(1, 32'h0, 7, 0, 0); drv(1, 32'h0, 9, 0, 0);
        drv(1, 32'h10, 3, 0, 0); drv(1, 32'h4, 8, 0, 0);
        idle(2);
        drv(0, 0, 0, 0, 1); probe("clear_dup");

        // Final masked write on the timeout cycle: DONE wins
        exp_mask = 4'b0001; exp_data = {96'd0, 32'd7};
        sb.push_back(mk("simultaneous", 1, 1, 0, 0, 4'b0001, {96'd0, 32'd7}, 4'h0, 10, 1));
        drv(0, 0, 0, 1, 0); idle(9);
        drv(1, 32'h0, 7, 0, 0);
        idle(3);
        drv(0, 0, 0, 0, 1); probe("clear_simul");

        // Empty mask finishes one cycle after start; then clear beats start
        exp_mask = 4'h0;
        sb.push_back(mk("mask_zero", 1, 1, 0, 0, 4'h0, '0, 4'h0, 1, 0));
        drv(0, 0, 0, 1, 0); idle(2);
        drv(0, 0, 0, 1, 1); probe("clear_and_start");
        idle(1); probe("clear_and_start_hold");

        // Reset mid-RUN aborts
        exp_mask = 4'hF; exp_data = DATA_4321;
        drv(0, 0, 0, 1, 0); drv(1, 32'h0, 1, 0, 0); drv(1, 32'h4, 2, 0, 0);
        drv(0, 0, 0, 0, 0, 1'b0); probe("reset_mid_run");
        idle(3);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_result_monitor.md
Name: mmio_result_monitor

Overview:
- Synthesizable, parametrised result sink for the MIPS computer top level. It replaces the single hard-wired "write to address 0 ends the run" check.
- Snoops the data-memory write bus (memwrite/dataadr/writedata) and latches writes to NUM_CH consecutive result addresses.
- Compares each latched value against an expected value. Raises done/pass, or raises timeout when a cycle watchdog expires.
- Sits beside dmem in the computer wrapper. Usable in simulation and on FPGA.

Parameters:
- DATA_WIDTH, 32, width of writedata and expected values
- ADDR_WIDTH, 32, width of dataadr
- NUM_CH, 4, number of result channels (1..16)
- BASE_ADDR, 0, byte address of channel 0
- ADDR_STRIDE, 4, byte spacing between channels
- TIMEOUT_CYCLES, 100000, RUN cycles before timeout (≥1)
- CNT_WIDTH, 32, width of the cycle and write counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse: IDLE→RUN
- clear  in  1  one-cycle pulse: any state→IDLE, clears captures
- memwrite  in  1  data-memory write enable
- dataadr  in  ADDR_WIDTH  data-memory address
- writedata  in  DATA_WIDTH  data-memory write data
- exp_mask  in  NUM_CH  channels that must be written and checked
- exp_data  in  NUM_CH*DATA_WIDTH  expected values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  state==RUN
- done  out  1  state==DONE
- pass  out  1  valid when done; all masked channels matched
- timeout  out  1  state==TIMEOUT
- cap_valid  out  NUM_CH  channel i captured
- cap_data  out  NUM_CH*DATA_WIDTH  captured values
- dup_write  out  NUM_CH  channel written again after capture (sticky)
- cycle_count  out  CNT_WIDTH  cycles spent in RUN
- write_count  out  CNT_WIDTH  total memwrite cycles in RUN, any address

Behaviour:
- Reset (reset==0 at a rising edge) puts the block in state IDLE and zeroes every output and counter. Reset asserted mid-RUN aborts the run the same way.
- States: IDLE, RUN, DONE, TIMEOUT.
- IDLE→RUN: on start. start in any other state is ignored.
- clear: returns any state to IDLE and zeroes captures, flags and counters. clear beats start in the same cycle.
- Channel hit: memwrite && dataadr == BASE_ADDR + i*ADDR_STRIDE, compared at full ADDR_WIDTH.
- Hits are acted on only in RUN. Writes in IDLE, DONE or TIMEOUT are ignored.
- First hit on channel i latches writedata into cap_data[i] and sets cap_valid[i] on the next edge.
- Later hits on a captured channel leave cap_data unchanged and set dup_write[i].
- Hits on unmasked channels are still captured; they do not affect done or pass.
- write_count increments on every memwrite cycle in RUN. cycle_count increments every RUN cycle. Both saturate at all-ones.
- RUN→DONE: on the edge after every channel with exp_mask[i]==1 has cap_valid[i]==1. The final capture and the DONE transition land on the same edge, since completion is computed from next-state cap_valid.
- pass = AND over masked channels of (cap_data[i]==exp_data[i]), registered on the same edge as DONE.
- exp_mask all zero: DONE with pass=1 one cycle after start.
- RUN→TIMEOUT: when cycle_count reaches TIMEOUT_CYCLES-1 and completion is not met. If the final capture and timeout land in the same cycle, DONE wins.
- DONE and TIMEOUT hold until clear or reset. pass=0 in TIMEOUT.
- exp_mask and exp_data are sampled continuously. Software holds them stable during RUN.

Optional Feature:
- Macro: MMIO_RESULT_MONITOR_STOP_ON_MISMATCH_EN.
- Defined: the first capture on a masked channel whose value differs from exp_data[i] moves RUN→DONE on that same edge with pass=0, without waiting for the remaining channels.
- Undefined: the block always waits for every masked channel or for timeout.

Decomposition:
- Package mmio_result_monitor_pkg holds:
  - the state enum (IDLE, RUN, DONE, TIMEOUT)
  - a function chan_addr(i) returning BASE_ADDR + i*ADDR_STRIDE
  - default parameter constants
- One sub-module, monitor_watchdog: a saturating cycle counter with enable, clear and expired output, parameterised by CNT_WIDTH and TIMEOUT_CYCLES.

Test Plan:
- Nominal: NUM_CH=4, exp_mask=4'b1111, exp_data={4,3,2,1}; start, then write 1,2,3,4 to addresses 0,4,8,0xC on consecutive cycles → done=1 on the edge after the 4th write, pass=1, write_count=4, cycle_count=5.
- Mismatch: as above but write 5 to address 8 → done=1, pass=0, cap_data[2]=5. With STOP_ON_MISMATCH_EN, done=1 on the edge after the addr-8 write, cap_valid=4'b0111.
- Timeout: TIMEOUT_CYCLES=10, exp_mask=4'b0001, no writes → timeout=1 after 10 RUN cycles, done=0, pass=0.
- Duplicate/ignored writes:
  - write 7 then 9 to address 0 → cap_data[0]=7, dup_write[0]=1
  - write to address 0x10 → no capture, write_count still increments
  - write to address 0 in IDLE → ignored
- Simultaneous boundary: the final masked write lands on the timeout cycle → done=1, timeout=0.
- Reset/clear: reset=0 mid-RUN → all outputs 0, state IDLE. In DONE, clear and start together → IDLE, all captures cleared.
